// File: rtl/count_display_pkg.sv
// count_display_pkg
// Shared definitions for the two-digit multiplexed count display:
//   - scan_state_t : the four scan phases of one display frame
//   - MAX_COUNT    : largest legal upstream count; anything above shows dashes
//   - SEG_*        : active-low segment patterns {g,f,e,d,c,b,a}
//   - digit_seg()  : BCD digit to segment pattern (non-digits map to blank)
package count_display_pkg;

  typedef enum logic [1:0] {
    UNITS = 2'd0,
    GAP_U = 2'd1,
    TENS  = 2'd2,
    GAP_T = 2'd3
  } scan_state_t;

  localparam logic [4:0] MAX_COUNT = 5'd19;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/count_display_seg7_decode.sv
// seg7_decode
// Combinational segment lookup.
//   code  [3:0] in  : BCD digit to show
//   dash        in  : show a dash instead of the digit
//   blank       in  : show nothing (wins over dash and code)
//   seg   [6:0] out : active-low segments {g,f,e,d,c,b,a}
module seg7_decode
  import count_display_pkg::*;
(
  input  logic [3:0] code,
  input  logic       dash,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    if (blank) begin
      seg = SEG_BLANK;
    end else if (dash) begin
      seg = SEG_DASH;
    end else begin
      seg = digit_seg(code);
    end
  end

endmodule

// File: rtl/count_display.sv
// count_display
// Two-digit time-multiplexed 7-segment driver for a mod-20 counter.
// A frame is UNITS (SCAN_DIV cycles), GAP_U (1), TENS (SCAN_DIV), GAP_T (1).
// The count and direction are sampled once per frame in GAP_T so a frame
// never shows a half-updated value.
//   mclk        in  : clock, rising edge
//   reset       in  : synchronous, active-high
//   value [4:0] in  : count 0..19 (20..31 displays dashes)
//   dir         in  : 1 = counting down (lights the units decimal point)
//   seg   [6:0] out : active-low segments {g,f,e,d,c,b,a}, registered
//   an    [1:0] out : active-low digit enables, an[0]=units, an[1]=tens
//   dp          out : active-low units decimal point, registered
module count_display
  import count_display_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic [4:0] value,
  input  logic       dir,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       dp
);

  localparam int              PW         = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);

  scan_state_t   state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    snap_value_q, snap_value_d;
  logic          snap_dir_q, snap_dir_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          dp_q, dp_d;

  // State register and registered outputs
  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q      <= UNITS;
      presc_q      <= '0;
      snap_value_q <= '0;
      snap_dir_q   <= 1'b0;
      seg_q        <= SEG_BLANK;
      an_q         <= 2'b11;
      dp_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      snap_value_q <= snap_value_d;
      snap_dir_q   <= snap_dir_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      dp_q         <= dp_d;
    end
  end

  // Next-state: prescaler paces the lit states, gaps last one cycle,
  // and the snapshot is taken only in GAP_T.
  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q + 1'b1;
    snap_value_d = snap_value_q;
    snap_dir_d   = snap_dir_q;
    case (state_q)
      UNITS: begin
        if (presc_q == PRESC_LAST) begin
          state_d = GAP_U;
          presc_d = '0;
        end
      end
      GAP_U: begin
        state_d = TENS;
        presc_d = '0;
      end
      TENS: begin
        if (presc_q == PRESC_LAST) begin
          state_d = GAP_T;
          presc_d = '0;
        end
      end
      default: begin
        state_d      = UNITS;
        presc_d      = '0;
        snap_value_d = value;
        snap_dir_d   = dir;
      end
    endcase
  end

  // Digit split of the snapshot
  logic       snap_dash;
  logic       snap_tens;
  logic [3:0] units_code;
  logic       tens_blank;

  assign snap_dash  = (snap_value_q > MAX_COUNT);
  assign snap_tens  = (snap_value_q >= 5'd10);
  assign units_code = snap_tens ? 4'(snap_value_q - 5'd10) : snap_value_q[3:0];
  // Dashes are always shown on both digits, so blanking never applies to them
  assign tens_blank = BLANK_LZ && !snap_tens && !snap_dash;

  logic [3:0] dec_code;
  logic       dec_blank;
  logic [6:0] dec_seg;

  seg7_decode u_seg7_decode (
    .code  (dec_code),
    .dash  (snap_dash),
    .blank (dec_blank),
    .seg   (dec_seg)
  );

  // Output decode from the current state; registered above, hence the
  // one-cycle latency. At most one anode is ever driven low.
  always_comb begin
    dec_code  = units_code;
    dec_blank = 1'b1;
    an_d      = 2'b11;
    dp_d      = 1'b1;
    case (state_q)
      UNITS: begin
        dec_blank = 1'b0;
        an_d      = 2'b10;
        dp_d      = snap_dash ? 1'b1 : ~snap_dir_q;
      end
      TENS: begin
        dec_code  = {3'b000, snap_tens};
        dec_blank = tens_blank;
        an_d      = tens_blank ? 2'b11 : 2'b01;
      end
      default: begin
        dec_blank = 1'b1;
      end
    endcase
    seg_d = dec_seg;
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule
